bg_affine_stepper: RTL

BG_AFFINE_STEPPER -- requirements
Module: bg_affine_stepper

---
 rtl/bg_pkg.sv | 27 ++
 rtl/bg_coord_clip.sv | 42 ++++
 rtl/bg_affine_stepper.sv | 136 +++++++++++++
 3 files changed

// File: rtl/bg_pkg.sv
//------------------------------------------------------------------------------
// Module  : bg_pkg
// Brief   : Shared constants, FSM state type and step sign-extension helper
//           for the background affine stepper.
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package bg_pkg;

  localparam int LINE_PIXELS_DEF = 240;
  localparam int FRAC_BITS       = 8;
  localparam int REF_W           = 28;
  localparam int INT_W           = REF_W - FRAC_BITS;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } bg_state_e;

  function automatic logic [REF_W-1:0] sext_step(input logic [15:0] s);
    return {{(REF_W-16){s[15]}}, s};
  endfunction

endpackage

`default_nettype wire

// File: rtl/bg_coord_clip.sv
//------------------------------------------------------------------------------
// Module  : bg_coord_clip
// Brief   : Per-axis range check / wrap of a signed integer BG coordinate.
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module bg_coord_clip
  import bg_pkg::*;
(
  input  logic [INT_W-1:0] coord_i,
  input  logic [9:0]       limit_i,
  input  logic             overflow_i,
  input  logic             bitmapped_i,
  output logic [9:0]       coord_o,
  output logic             transparent_o
);

  logic w_neg;
  logic w_above;
  logic w_at;

  assign w_neg   = coord_i[INT_W-1];
  assign w_above = !w_neg && (coord_i > INT_W'(limit_i));
  assign w_at    = (coord_i == INT_W'(limit_i));

  // Bitmap limits are exclusive widths, tiled limits are inclusive masks.
  always_comb begin
    coord_o       = coord_i[9:0];
    transparent_o = 1'b0;
    if (bitmapped_i) begin
      transparent_o = w_neg | w_above | w_at;
    end else if (overflow_i) begin
      coord_o = coord_i[9:0] & limit_i;
    end else begin
      transparent_o = w_neg | w_above;
    end
  end

endmodule

`default_nettype wire

// File: rtl/bg_affine_stepper.sv
//------------------------------------------------------------------------------
// Module  : bg_affine_stepper
// Brief   : Per-scanline affine / text-scroll BG coordinate generator with
//           valid/ready pixel output.
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module bg_affine_stepper
  import bg_pkg::*;
#(
  parameter int LINE_PIXELS = LINE_PIXELS_DEF
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [27:0] bgx,
  input  logic [27:0] bgy,
  input  logic [15:0] dx,
  input  logic [15:0] dy,
  input  logic [15:0] dmx,
  input  logic [15:0] dmy,
  input  logic [9:0]  hofs,
  input  logic [9:0]  vofs,
  input  logic [9:0]  hmax,
  input  logic [9:0]  vmax,
  input  logic        rotate,
  input  logic        bitmapped,
  input  logic        overflow,
  input  logic        line_start,
  input  logic        hblank,
  input  logic        vblank,
  input  logic        pix_ready,
  output logic        pix_valid,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic        pix_transparent,
  output logic        pix_last
);

  localparam logic [7:0] LAST_IDX = 8'(LINE_PIXELS - 1);

  bg_state_e   state_q;
  logic [27:0] refx_q, refy_q, curx_q, cury_q;
  logic [7:0]  line_q, index_q;

  logic [27:0] curx_d, cury_d;
  logic [7:0]  index_d;
  logic        w_load;
  logic        w_take;
  logic [9:0]  w_clip_x, w_clip_y;
  logic        w_tr_x, w_tr_y;
  logic [9:0]  w_pix_x, w_pix_y;
  logic        w_pix_tr;

  assign w_load  = (state_q == ST_IDLE) && line_start;
  assign w_take  = w_load || ((state_q == ST_EMIT) && pix_ready && !pix_last);
  assign curx_d  = w_load ? refx_q : curx_q + sext_step(dx);
  assign cury_d  = w_load ? refy_q : cury_q + sext_step(dy);
  assign index_d = w_load ? 8'd0   : index_q + 8'd1;

  // Output coordinates are computed from the next position so they register
  // together with it and stay frozen while downstream stalls.
  bg_coord_clip u_clip_x (
    .coord_i       (curx_d[REF_W-1:FRAC_BITS]),
    .limit_i       (hmax),
    .overflow_i    (overflow),
    .bitmapped_i   (bitmapped),
    .coord_o       (w_clip_x),
    .transparent_o (w_tr_x)
  );

  bg_coord_clip u_clip_y (
    .coord_i       (cury_d[REF_W-1:FRAC_BITS]),
    .limit_i       (vmax),
    .overflow_i    (overflow),
    .bitmapped_i   (bitmapped),
    .coord_o       (w_clip_y),
    .transparent_o (w_tr_y)
  );

  always_comb begin
    w_pix_x  = ({2'b00, index_d} + hofs) & hmax;
    w_pix_y  = ({2'b00, line_q} + vofs) & vmax;
    w_pix_tr = 1'b0;
    if (rotate) begin
      w_pix_x  = w_clip_x;
      w_pix_y  = w_clip_y;
      w_pix_tr = w_tr_x | w_tr_y;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= ST_IDLE;
      refx_q          <= '0;
      refy_q          <= '0;
      curx_q          <= '0;
      cury_q          <= '0;
      line_q          <= '0;
      index_q         <= '0;
      pix_valid       <= 1'b0;
      pix_x           <= '0;
      pix_y           <= '0;
      pix_transparent <= 1'b0;
      pix_last        <= 1'b0;
    end else begin
      if (vblank) begin
        refx_q <= bgx;
        refy_q <= bgy;
        line_q <= '0;
      end else if (hblank) begin
        refx_q <= refx_q + sext_step(dmx);
        refy_q <= refy_q + sext_step(dmy);
        line_q <= line_q + 8'd1;
      end

      if (w_take) begin
        state_q         <= ST_EMIT;
        pix_valid       <= 1'b1;
        curx_q          <= curx_d;
        cury_q          <= cury_d;
        index_q         <= index_d;
        pix_x           <= w_pix_x;
        pix_y           <= w_pix_y;
        pix_transparent <= w_pix_tr;
        pix_last        <= (index_d == LAST_IDX);
      end else if ((state_q == ST_EMIT) && pix_ready) begin
        state_q   <= ST_IDLE;
        pix_valid <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire
